multi_timer: RTL and testbench
==============================

# multi_timer

Parameterised multi-channel down-counting timer on the picoRV memory-mapped peripheral bus. It is the successor to the single-channel systick.
- Each channel has its own 16-bit prescaler, reload value, periodic or one-shot mode, a write-1-to-clear pending flag and a maskable interrupt.
- Per-channel interrupts drive a vector output and a combined line for the CPU.

## Interface
- CHANNELS, default 4: number of independent channels, legal range 1..16.
- WIDTH, default 32: counter/reload width in bits, legal range 8..32.
- clk  input  1  system clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- select  input  1  bus select, already address-decoded for this block's 256-byte window.
- wstrb  input  4  byte write strobes; 0000 = read.
- addr  input  8  byte offset. [7:4] = channel index, [3:2] = register, [1:0] ignored.
- data_i  input  32  write data.
- ready  output  1  transaction-complete pulse.
- data_o  output  32  read data.
- irq  output  1  OR of irq_vec.
- irq_vec  output  CHANNELS  per-channel interrupt: pending & irq_en.

## Operation
Each channel occupies 16 bytes at channel×0x10. Registers:
- 0x0 CTRL
  - bit0 enable; bit1 irq_en; bit2 oneshot (1 = one-shot, 0 = periodic).
  - [31:16] prescaler P.
  - Other bits read 0.
- 0x4 COUNT: read returns the current counter; a write loads the counter.
- 0x8 RELOAD: reload value R.
- 0xC STATUS
  - bit0 pending: write 1 to clear.
  - bit1 running: read-only, equals enable.
  - Other bits read 0.

Width and access rules:
- Register bits at and above WIDTH in COUNT/RELOAD read 0; writes to them are ignored.
- wstrb applies per byte to all writable fields.
- Channel index ≥ CHANNELS: the transaction completes normally, reads return 0, writes are ignored.

Per-channel counting:
- Prescaler counter pc runs 0..P while enable=1. A tick occurs when pc==P, and pc then returns to 0.
- On a tick:
  - If count==0: set pending, load count←R, and if oneshot, clear enable.
  - Otherwise: count←count−1.
- Enable rising edge (a CTRL write changing enable 0→1) loads count←R and pc←0. Rewriting enable=1 while already enabled does not reload.
- Clearing enable freezes count and resets pc to 0.

Simultaneous events:
- Software COUNT write in the same cycle as a tick: the write wins and the tick is discarded.
- W1C of pending in the same cycle as an expiry: the set wins, and pending stays 1.
- CTRL write with enable=0 in the same cycle as a one-shot expiry: pending is set and enable ends at 0.

Reset, applied at any time including mid-transaction:
- All registers, pc, ready, data_o, irq and irq_vec go to 0 asynchronously.
- An in-flight transaction is abandoned.

## Timing
- Transaction acceptance:
  - A transaction is accepted on a rising edge where select=1 and ready=0.
  - ready is 1 for exactly one cycle, in the cycle after acceptance.
  - ready returns to 0 on the following edge even if select is still high.
  - A select held continuously is re-accepted on the edge after ready falls.
- Writes update registers at the edge that raises ready.
- data_o:
  - Valid while ready=1, reflecting register state at the acceptance edge.
  - 0 when ready=0.
- Enable latency: the first tick occurs P+1 cycles after the edge that raises ready for the enabling write.
- Periodic period: (P+1)×(R+1) cycles between successive pending sets.
- Outputs:
  - irq_vec/irq are registered and rise one cycle after pending is set.
  - irq_vec/irq fall one cycle after the clear (W1C or irq_en←0).

## Test plan
- Reset and read-back
  - Stimulus: hold reset 5 cycles, release; read every register of channels 0..3.
  - Required response: all reads return 0; irq=0; ready pulses exactly one cycle per read.
- Periodic mode
  - Stimulus: channel 0, R=3, CTRL=0x00020003 (P=2, irq_en, enable).
  - Required response: pending is set every 12 cycles; irq rises 1 cycle after each set.
  - Required response: COUNT reads cycle 3→2→1→0 with 3 cycles per step.
- One-shot and W1C
  - Stimulus: channel 1, R=1, CTRL=0x00000007.
  - Required response: after 2 cycles pending=1, enable=0, and STATUS reads 0x1.
  - Stimulus: write 0x1 to STATUS.
  - Required response: STATUS reads 0x0; irq_vec[1] falls the next cycle.
- Collisions
  - Stimulus: COUNT write of 0x10 in the same cycle as a tick.
  - Required response: COUNT reads 0x10.
  - Stimulus: W1C in the same cycle as an expiry.
  - Required response: pending remains 1.
- Width, strobes and unmapped channel
  - Stimulus: WIDTH=8; write RELOAD=0xFFFFFFFF with wstrb=0001.
  - Required response: RELOAD reads 0xFF.
  - Stimulus: with CHANNELS=4, access address 0x50.
  - Required response: ready pulses, reads return 0, no channel changes.
- Independence and reset mid-run
  - Stimulus: channels 0 and 2 run with different P/R.
  - Required response: irq_vec periods are each correct; irq is their OR.
  - Stimulus: assert reset while ready=1.
  - Required response: ready, irq and all counters are 0 immediately.

Source files
------------

// File: rtl/multi_timer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | multi_timer_if : picoRV-style memory-mapped peripheral bus            |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
interface multi_timer_if;
  logic        select;
  logic [3:0]  wstrb;
  logic [7:0]  addr;
  logic [31:0] data_i;
  logic        ready;
  logic [31:0] data_o;

  modport master (
    output select, wstrb, addr, data_i,
    input  ready, data_o
  );

  modport slave (
    input  select, wstrb, addr, data_i,
    output ready, data_o
  );
endinterface
`default_nettype wire

// File: rtl/multi_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | multi_timer : multi-channel prescaled down-counting timer with IRQs   |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module multi_timer #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32
) (
  input  wire                 clk,
  input  wire                 reset,
  multi_timer_if.slave        bus,
  output logic                irq,
  output logic [CHANNELS-1:0] irq_vec
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_RELOAD = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic                accept;
  logic                wr_en;
  logic [3:0]          ch_idx;
  logic [1:0]          reg_sel;
  logic [31:0]         wmask;
  logic [WIDTH-1:0]    wmask_w;
  logic [WIDTH-1:0]    wdata_w;
  logic [31:0]         ch_rd [CHANNELS];
  logic [CHANNELS-1:0] irq_src;
  logic [31:0]         rd_mux;
  logic                unused_bits;

  logic                ready_q,   ready_d;
  logic [31:0]         data_o_q,  data_o_d;
  logic                irq_q,     irq_d;
  logic [CHANNELS-1:0] irq_vec_q, irq_vec_d;

  // A held select is only re-accepted once ready has dropped again.
  assign accept  = bus.select && !ready_q;
  assign wr_en   = accept && (bus.wstrb != 4'b0000);
  assign ch_idx  = bus.addr[7:4];
  assign reg_sel = bus.addr[3:2];
  assign wmask   = {{8{bus.wstrb[3]}}, {8{bus.wstrb[2]}},
                    {8{bus.wstrb[1]}}, {8{bus.wstrb[0]}}};
  assign wmask_w = wmask[WIDTH-1:0];
  assign wdata_w = bus.data_i[WIDTH-1:0];

  assign unused_bits = ^{bus.addr[1:0], wmask[15:8], bus.data_i[15:8]};

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic             enable_q,  enable_d;
    logic             irq_en_q,  irq_en_d;
    logic             oneshot_q, oneshot_d;
    logic             pending_q, pending_d;
    logic [15:0]      presc_q,   presc_d;
    logic [15:0]      pc_q,      pc_d;
    logic [WIDTH-1:0] count_q,   count_d;
    logic [WIDTH-1:0] reload_q,  reload_d;
    logic             hit;
    logic             raw_tick;
    logic             tick;
    logic             expire;
    logic             en_rise;
    logic [31:0]      rd_val;

    assign hit = wr_en && (ch_idx == 4'(g));

    always_comb begin
      enable_d  = enable_q;
      irq_en_d  = irq_en_q;
      oneshot_d = oneshot_q;
      pending_d = pending_q;
      presc_d   = presc_q;
      count_d   = count_q;
      reload_d  = reload_q;
      en_rise   = 1'b0;

      // A software COUNT write swallows a coincident tick; pc still wraps.
      raw_tick = enable_q && (pc_q == presc_q);
      tick     = raw_tick && !(hit && reg_sel == REG_COUNT);
      expire   = tick && (count_q == '0);

      if (hit && reg_sel == REG_CTRL) begin
        if (bus.wstrb[0]) begin
          enable_d  = bus.data_i[0];
          irq_en_d  = bus.data_i[1];
          oneshot_d = bus.data_i[2];
          en_rise   = bus.data_i[0] && !enable_q;
        end
        presc_d = (presc_q & ~wmask[31:16]) | (bus.data_i[31:16] & wmask[31:16]);
      end
      if (expire && oneshot_q) begin
        enable_d = 1'b0;
      end

      if (tick) begin
        count_d = expire ? reload_q : count_q - WIDTH'(1);
      end
      if (en_rise) begin
        count_d = reload_q;
      end
      if (hit && reg_sel == REG_COUNT) begin
        count_d = (count_q & ~wmask_w) | (wdata_w & wmask_w);
      end
      if (hit && reg_sel == REG_RELOAD) begin
        reload_d = (reload_q & ~wmask_w) | (wdata_w & wmask_w);
      end

      // An expiry in the same cycle as the clear keeps the flag set.
      if (hit && reg_sel == REG_STATUS && bus.wstrb[0] && bus.data_i[0]) begin
        pending_d = 1'b0;
      end
      if (expire) begin
        pending_d = 1'b1;
      end

      pc_d = (!enable_d || en_rise || raw_tick) ? 16'd0 : pc_q + 16'd1;
    end

    always_comb begin
      rd_val = 32'd0;
      case (reg_sel)
        REG_CTRL:   rd_val = {presc_q, 13'd0, oneshot_q, irq_en_q, enable_q};
        REG_COUNT:  rd_val = 32'(count_q);
        REG_RELOAD: rd_val = 32'(reload_q);
        default:    rd_val = {30'd0, enable_q, pending_q};
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        enable_q  <= 1'b0;
        irq_en_q  <= 1'b0;
        oneshot_q <= 1'b0;
        pending_q <= 1'b0;
        presc_q   <= 16'd0;
        pc_q      <= 16'd0;
        count_q   <= '0;
        reload_q  <= '0;
      end else begin
        enable_q  <= enable_d;
        irq_en_q  <= irq_en_d;
        oneshot_q <= oneshot_d;
        pending_q <= pending_d;
        presc_q   <= presc_d;
        pc_q      <= pc_d;
        count_q   <= count_d;
        reload_q  <= reload_d;
      end
    end

    assign ch_rd[g]   = rd_val;
    assign irq_src[g] = pending_q && irq_en_q;
  end

  // Unmapped channel indices match no channel and read back as zero.
  always_comb begin
    rd_mux = 32'd0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_idx == 4'(i)) begin
        rd_mux = ch_rd[i];
      end
    end
  end

  always_comb begin
    ready_d   = accept;
    data_o_d  = (accept && bus.wstrb == 4'b0000) ? rd_mux : 32'd0;
    irq_vec_d = irq_src;
    irq_d     = |irq_src;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q   <= 1'b0;
      data_o_q  <= 32'd0;
      irq_q     <= 1'b0;
      irq_vec_q <= '0;
    end else begin
      ready_q   <= ready_d;
      data_o_q  <= data_o_d;
      irq_q     <= irq_d;
      irq_vec_q <= irq_vec_d;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.data_o = data_o_q;
  assign irq        = irq_q;
  assign irq_vec    = irq_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_multi_timer : directed self-checking bench for multi_timer         |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_multi_timer;

  logic       clk;
  logic       reset;
  logic       irq;
  logic [3:0] irq_vec;
  logic       irq8;
  logic [1:0] irq_vec8;

  multi_timer_if bus ();
  multi_timer_if bus8 ();

  multi_timer #(.CHANNELS(4), .WIDTH(32)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .irq     (irq),
    .irq_vec (irq_vec)
  );

  multi_timer #(.CHANNELS(2), .WIDTH(8)) u_dut8 (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus8),
    .irq     (irq8),
    .irq_vec (irq_vec8)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  logic        rdy_ack;
  logic        rdy_idle;
  logic [31:0] dout_idle;
  logic [3:0]  irqv_ack;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Starts just after a clock edge with ready low; returns one cycle after ready.
  task automatic xfer(input bit w8, input logic [7:0] a, input logic [3:0] s,
                      input logic [31:0] d, output logic [31:0] rd);
    if (w8) begin
      bus8.select = 1'b1; bus8.addr = a; bus8.wstrb = s; bus8.data_i = d;
    end else begin
      bus.select = 1'b1; bus.addr = a; bus.wstrb = s; bus.data_i = d;
    end
    @(posedge clk); #1;
    rdy_ack  = w8 ? bus8.ready : bus.ready;
    rd       = w8 ? bus8.data_o : bus.data_o;
    irqv_ack = irq_vec;
    bus.select  = 1'b0; bus.wstrb  = 4'h0;
    bus8.select = 1'b0; bus8.wstrb = 4'h0;
    @(posedge clk); #1;
    rdy_idle  = w8 ? bus8.ready : bus.ready;
    dout_idle = w8 ? bus8.data_o : bus.data_o;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    xfer(1'b0, a, 4'hF, d, dummy);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    xfer(1'b0, a, 4'h0, 32'd0, d);
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  pattern;

    reset = 1'b1;
    bus.select  = 1'b0; bus.wstrb  = 4'h0; bus.addr  = 8'h00; bus.data_i  = 32'd0;
    bus8.select = 1'b0; bus8.wstrb = 4'h0; bus8.addr = 8'h00; bus8.data_i = 32'd0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_ready_irq", {26'd0, bus.ready, irq, irq_vec}, 32'd0);
    check("rst_data_o", bus.data_o, 32'd0);
    reset = 1'b0;

    // Reset values and single-cycle ready per read
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        rd(8'(c * 16 + r * 4), d);
        check("rst_read", d, 32'd0);
        check("rst_ready_pulse", {30'd0, rdy_ack, rdy_idle}, 32'h2);
      end
    end
    check("rst_irq_after_reads", {31'd0, irq}, 32'd0);

    bus.select = 1'b1; bus.addr = 8'h04; bus.wstrb = 4'h0;
    pattern = 4'h0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      pattern = {pattern[2:0], bus.ready};
    end
    bus.select = 1'b0;
    check("held_select_ready", {28'd0, pattern}, 32'hA);

    // Periodic: ch0 R=3 P=2 -> expiry every 12 cycles
    wr(8'h08, 32'd3);
    wr(8'h00, 32'h0002_0003);
    repeat (11) @(posedge clk);
    #1;
    check("per_irq_before", {30'd0, irq, irq_vec[0]}, 32'h0);
    @(posedge clk); #1;
    check("per_irq_first", {30'd0, irq, irq_vec[0]}, 32'h3);
    wr(8'h0C, 32'd1);
    check("per_w1c_irq_still_high", {31'd0, irqv_ack[0]}, 32'd1);
    check("per_w1c_irq_fell", {31'd0, irq_vec[0]}, 32'd0);
    repeat (9) @(posedge clk);
    #1;
    check("per_irq_second_before", {31'd0, irq_vec[0]}, 32'd0);
    @(posedge clk); #1;
    check("per_irq_second", {31'd0, irq_vec[0]}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      rd(8'h04, d);
      check("per_count_step", d, 32'(3 - k));
      if (k == 0) check("per_data_o_idle", dout_idle, 32'd0);
      @(posedge clk); #1;
    end
    wr(8'h00, 32'd0);
    wr(8'h0C, 32'd1);

    // One-shot: ch1 R=1 P=0 -> expiry two cycles after enable
    wr(8'h18, 32'd1);
    wr(8'h10, 32'h0000_0007);
    @(posedge clk); #1;
    rd(8'h1C, d);
    check("os_status", d, 32'h1);
    rd(8'h10, d);
    check("os_ctrl_enable_cleared", d, 32'h6);
    check("os_irq_vec1", {31'd0, irq_vec[1]}, 32'd1);
    wr(8'h1C, 32'd1);
    check("os_w1c_irq_at_ack", {31'd0, irqv_ack[1]}, 32'd1);
    check("os_w1c_irq_fell", {31'd0, irq_vec[1]}, 32'd0);
    rd(8'h1C, d);
    check("os_status_cleared", d, 32'h0);
    rd(8'h14, d);
    check("os_count_reloaded", d, 32'd1);

    // Byte strobes on a 32-bit channel
    xfer(1'b0, 8'h18, 4'b0101, 32'hAABB_CCDD, d);
    rd(8'h18, d);
    check("strb_reload", d, 32'h00BB_00DD);
    xfer(1'b0, 8'h10, 4'b1000, 32'hFFFF_FFFF, d);
    rd(8'h10, d);
    check("strb_ctrl", d, 32'hFF00_0006);

    // COUNT write colliding with a tick: ch3 R=5 P=3, ticks every 4 cycles
    wr(8'h38, 32'd5);
    wr(8'h30, 32'h0003_0001);
    repeat (6) @(posedge clk);
    #1;
    wr(8'h34, 32'h10);
    rd(8'h34, d);
    check("col_count_write_wins", d, 32'h10);
    wr(8'h30, 32'd0);

    // W1C colliding with an expiry: ch3 R=0 P=3 expires every 4 cycles
    wr(8'h38, 32'd0);
    wr(8'h30, 32'h0003_0001);
    repeat (6) @(posedge clk);
    #1;
    wr(8'h3C, 32'd1);
    rd(8'h3C, d);
    check("col_w1c_set_wins", d, 32'h3);
    wr(8'h30, 32'd0);
    wr(8'h3C, 32'd1);
    rd(8'h3C, d);
    check("col_status_cleared", d, 32'h0);

    // WIDTH=8 instance
    xfer(1'b1, 8'h08, 4'b0001, 32'hFFFF_FFFF, d);
    xfer(1'b1, 8'h08, 4'b0000, 32'd0, d);
    check("w8_reload", d, 32'h0000_00FF);
    xfer(1'b1, 8'h04, 4'hF, 32'h1234_5678, d);
    xfer(1'b1, 8'h04, 4'b0000, 32'd0, d);
    check("w8_count", d, 32'h0000_0078);

    // Unmapped channel 5
    wr(8'h58, 32'h1234);
    check("unmap_wr_ready", {30'd0, rdy_ack, rdy_idle}, 32'h2);
    wr(8'h50, 32'hFFFF_0007);
    rd(8'h54, d);
    check("unmap_rd_count", d, 32'd0);
    check("unmap_rd_ready", {30'd0, rdy_ack, rdy_idle}, 32'h2);
    rd(8'h58, d);
    check("unmap_rd_reload", d, 32'd0);
    rd(8'h18, d);
    check("unmap_ch1_reload", d, 32'h00BB_00DD);
    rd(8'h10, d);
    check("unmap_ch1_ctrl", d, 32'hFF00_0006);

    // Independence: ch0 period 4 (P=1,R=1), ch2 period 5 (P=0,R=4)
    wr(8'h08, 32'd1);
    wr(8'h28, 32'd4);
    wr(8'h00, 32'h0001_0003);
    wr(8'h20, 32'h0000_0003);
    @(posedge clk); #1;
    check("ind_e4", {27'd0, irq, irq_vec}, 32'h00);
    @(posedge clk); #1;
    check("ind_e5", {27'd0, irq, irq_vec}, 32'h11);
    repeat (2) @(posedge clk);
    #1;
    check("ind_e7", {27'd0, irq, irq_vec}, 32'h11);
    @(posedge clk); #1;
    check("ind_e8", {27'd0, irq, irq_vec}, 32'h15);
    wr(8'h0C, 32'd1);
    check("ind_e10_ch0_cleared", {27'd0, irq, irq_vec}, 32'h14);
    repeat (2) @(posedge clk);
    #1;
    check("ind_e12", {27'd0, irq, irq_vec}, 32'h14);
    @(posedge clk); #1;
    check("ind_e13_ch0_period", {27'd0, irq, irq_vec}, 32'h15);
    wr(8'h2C, 32'd1);
    check("ind_e15_ch2_cleared", {27'd0, irq, irq_vec}, 32'h11);
    repeat (2) @(posedge clk);
    #1;
    check("ind_e17", {27'd0, irq, irq_vec}, 32'h11);
    @(posedge clk); #1;
    check("ind_e18_ch2_period", {27'd0, irq, irq_vec}, 32'h15);

    // Reset while ready is high
    bus.select = 1'b1; bus.addr = 8'h24; bus.wstrb = 4'h0;
    @(posedge clk); #1;
    check("mid_ready_before", {31'd0, bus.ready}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_ready_irq", {26'd0, bus.ready, irq, irq_vec}, 32'd0);
    check("mid_rst_data_o", bus.data_o, 32'd0);
    bus.select = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rd(8'h04, d);
    check("mid_ch0_count", d, 32'd0);
    rd(8'h24, d);
    check("mid_ch2_count", d, 32'd0);
    rd(8'h20, d);
    check("mid_ch2_ctrl", d, 32'd0);
    rd(8'h0C, d);
    check("mid_ch0_status", d, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("mid_irq_quiet", {27'd0, irq, irq_vec}, 32'd0);
    check("w8_irq_quiet", {29'd0, irq8, irq_vec8}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
